// File: rtl/bbox_merge_pkg.sv
// Shared widths, box record, FSM states and box-union helper for the bbox_merge block.
package bbox_merge_pkg;

    localparam int WIDTH_BITS  = 11;
    localparam int HEIGHT_BITS = 10;
    localparam int LABEL_WIDTH = 8;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  min_x;
        logic [HEIGHT_BITS-1:0] min_y;
        logic [WIDTH_BITS-1:0]  max_x;
        logic [HEIGHT_BITS-1:0] max_y;
    } bbox_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RESOLVE = 2'd1,
        EMIT    = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    function automatic bbox_t bbox_union(input bbox_t a, input bbox_t b);
        bbox_t r;
        r.min_x = (a.min_x < b.min_x) ? a.min_x : b.min_x;
        r.min_y = (a.min_y < b.min_y) ? a.min_y : b.min_y;
        r.max_x = (a.max_x > b.max_x) ? a.max_x : b.max_x;
        r.max_y = (a.max_y > b.max_y) ? a.max_y : b.max_y;
        return r;
    endfunction

endpackage

// File: rtl/bbox_merge_union_unit.sv
// Combinational bounding-box union: smallest box enclosing both inputs.
module bbox_union_unit
    import bbox_merge_pkg::*;
(
    input  bbox_t a,
    input  bbox_t b,
    output bbox_t y
);

    assign y = bbox_union(a, b);

endmodule

// File: rtl/bbox_merge.sv
// Per-label box table: collects partial boxes, resolves parent chains, streams merged roots.
// Optional macro BBOX_MERGE_MIN_SIZE_EN suppresses roots narrower/shorter than MIN_DIM.
module bbox_merge
    import bbox_merge_pkg::*;
#(
    parameter int MAX_LABELS = 32
`ifdef BBOX_MERGE_MIN_SIZE_EN
    , parameter int MIN_DIM  = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   bbox_valid,
    input  logic [LABEL_WIDTH-1:0] bbox_label,
    input  logic [LABEL_WIDTH-1:0] bbox_parent,
    input  logic [WIDTH_BITS-1:0]  bbox_min_x,
    input  logic [WIDTH_BITS-1:0]  bbox_max_x,
    input  logic [HEIGHT_BITS-1:0] bbox_min_y,
    input  logic [HEIGHT_BITS-1:0] bbox_max_y,
    input  logic                   frame_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_BITS-1:0]  out_min_x,
    output logic [WIDTH_BITS-1:0]  out_max_x,
    output logic [HEIGHT_BITS-1:0] out_min_y,
    output logic [HEIGHT_BITS-1:0] out_max_y,
    output logic [LABEL_WIDTH-1:0] out_label,
    output logic                   out_last,
    output logic                   busy,
    output logic                   drop_err
);

    // Output stream: a box transfers on a cycle with enable && out_valid && out_ready;
    // out_* stay stable while out_valid is high and out_ready is low.

    localparam int IDX_W = $clog2(MAX_LABELS);
    localparam logic [LABEL_WIDTH-1:0] MAX_L    = LABEL_WIDTH'(MAX_LABELS);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(MAX_LABELS - 1);

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [MAX_LABELS-1:0]  valid;
    logic [LABEL_WIDTH-1:0] parent [MAX_LABELS];
    bbox_t                  box    [MAX_LABELS];

    bbox_t                  in_box, col_union, rs_union;
    logic                   in_label_ok, in_geom_ok, accept;
    logic [IDX_W-1:0]       wr_idx, rs_pidx;
    logic [LABEL_WIDTH-1:0] new_par, rs_par;
    logic                   rs_is_child;
    logic [MAX_LABELS-1:0]  emittable;
    logic                   any_emit;
    logic [IDX_W-1:0]       last_sel;

    assign in_box = '{min_x: bbox_min_x, min_y: bbox_min_y,
                      max_x: bbox_max_x, max_y: bbox_max_y};
    assign in_label_ok = bbox_label < MAX_L;
    assign in_geom_ok  = (bbox_min_x <= bbox_max_x) && (bbox_min_y <= bbox_max_y);
    assign accept      = bbox_valid && (state == COLLECT) && in_label_ok && in_geom_ok;
    assign wr_idx      = bbox_label[IDX_W-1:0];
    // A parent outside the table or above the label cannot be a valid ancestor.
    assign new_par     = (bbox_parent >= MAX_L || bbox_parent > bbox_label) ? bbox_label : bbox_parent;

    assign rs_par      = parent[idx];
    assign rs_pidx     = rs_par[IDX_W-1:0];
    assign rs_is_child = valid[idx] && (rs_par != LABEL_WIDTH'(idx));

    bbox_union_unit u_collect_union (.a(box[wr_idx]),  .b(in_box),   .y(col_union));
    bbox_union_unit u_resolve_union (.a(box[rs_pidx]), .b(box[idx]), .y(rs_union));

`ifdef BBOX_MERGE_MIN_SIZE_EN
    function automatic logic big_enough(input bbox_t b);
        logic [WIDTH_BITS:0]  w;
        logic [HEIGHT_BITS:0] h;
        w = {1'b0, b.max_x} - {1'b0, b.min_x} + (WIDTH_BITS+1)'(1);
        h = {1'b0, b.max_y} - {1'b0, b.min_y} + (HEIGHT_BITS+1)'(1);
        return (w >= (WIDTH_BITS+1)'(MIN_DIM)) && (h >= (HEIGHT_BITS+1)'(MIN_DIM));
    endfunction
`endif

    always_comb begin
        emittable = '0;
        last_sel  = '0;
        for (int k = 0; k < MAX_LABELS; k++) begin
`ifdef BBOX_MERGE_MIN_SIZE_EN
            emittable[k] = valid[k] && big_enough(box[k]);
`else
            emittable[k] = valid[k];
`endif
            if (emittable[k]) last_sel = IDX_W'(k);
        end
        any_emit = |emittable;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            COLLECT: if (enable && frame_done) begin
                state_nx = RESOLVE;
                idx_nx   = LAST_IDX;
            end
            RESOLVE: if (enable) begin
                if (idx == IDX_W'(1)) begin
                    state_nx = EMIT;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx - IDX_W'(1);
                end
            end
            EMIT: if (enable && (!emittable[idx] || out_ready)) begin
                if (idx == LAST_IDX) state_nx = CLEAR;
                else                 idx_nx   = idx + IDX_W'(1);
            end
            CLEAR: if (enable) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= COLLECT;
            idx      <= '0;
            valid    <= '0;
            drop_err <= 1'b0;
            for (int k = 0; k < MAX_LABELS; k++) begin
                parent[k] <= '0;
                box[k]    <= '0;
            end
        end else if (enable) begin
            state <= state_nx;
            idx   <= idx_nx;
            if (bbox_valid && (busy || !in_label_ok || !in_geom_ok)) drop_err <= 1'b1;
            if (frame_done && busy) drop_err <= 1'b1;
            if (accept) begin
                valid[wr_idx]  <= 1'b1;
                box[wr_idx]    <= valid[wr_idx] ? col_union : in_box;
                parent[wr_idx] <= (valid[wr_idx] && parent[wr_idx] < new_par) ? parent[wr_idx] : new_par;
            end
            // Descending scan: every child is folded in before its parent is visited.
            if (state == RESOLVE && rs_is_child) begin
                if (valid[rs_pidx]) begin
                    box[rs_pidx] <= rs_union;
                    valid[idx]   <= 1'b0;
                end else begin
                    parent[idx] <= LABEL_WIDTH'(idx);
                end
            end
            if (state == CLEAR) valid <= '0;
        end
    end

    assign busy      = (state != COLLECT);
    assign out_valid = (state == EMIT) && emittable[idx];
    assign out_last  = (state == EMIT) &&
                       (any_emit ? (emittable[idx] && idx == last_sel) : (idx == LAST_IDX));
    assign out_min_x = out_valid ? box[idx].min_x : '0;
    assign out_min_y = out_valid ? box[idx].min_y : '0;
    assign out_max_x = out_valid ? box[idx].max_x : '0;
    assign out_max_y = out_valid ? box[idx].max_y : '0;
    assign out_label = out_valid ? LABEL_WIDTH'(idx) : '0;

endmodule

// File: tb/tb_bbox_merge.sv
// Randomized and directed bench for bbox_merge against a label-table reference model.
module tb_bbox_merge;
    import bbox_merge_pkg::*;

    localparam int NL = 32;
    localparam int W  = LABEL_WIDTH + 2*WIDTH_BITS + 2*HEIGHT_BITS;
`ifdef BBOX_MERGE_MIN_SIZE_EN
    localparam int MIN_SZ = 4;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   enable = 1'b0;
    logic                   bbox_valid = 1'b0;
    logic [LABEL_WIDTH-1:0] bbox_label = '0, bbox_parent = '0;
    logic [WIDTH_BITS-1:0]  bbox_min_x = '0, bbox_max_x = '0;
    logic [HEIGHT_BITS-1:0] bbox_min_y = '0, bbox_max_y = '0;
    logic                   frame_done = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid, out_last, busy, drop_err;
    logic [WIDTH_BITS-1:0]  out_min_x, out_max_x;
    logic [HEIGHT_BITS-1:0] out_min_y, out_max_y;
    logic [LABEL_WIDTH-1:0] out_label;

    always #5 clk = ~clk;

    bbox_merge dut (
        .clk(clk), .rst(rst), .enable(enable),
        .bbox_valid(bbox_valid), .bbox_label(bbox_label), .bbox_parent(bbox_parent),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .frame_done(frame_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_min_x(out_min_x), .out_max_x(out_max_x),
        .out_min_y(out_min_y), .out_max_y(out_max_y),
        .out_label(out_label), .out_last(out_last), .busy(busy), .drop_err(drop_err)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // Reference table: what each label has accumulated this frame.
    bit m_valid [NL];
    int m_parent[NL];
    int m_x0[NL], m_y0[NL], m_x1[NL], m_y1[NL];
    bit exp_drop;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    function automatic int root_of(input int i);
        int r = i;
        while (m_parent[r] != r && m_valid[m_parent[r]]) r = m_parent[r];
        return r;
    endfunction

    task automatic build_expected();
        int x0, y0, x1, y1;
        bit keep;
        exp_q.delete();
        for (int r = 0; r < NL; r++) begin
            if (m_valid[r] && root_of(r) == r) begin
                x0 = 9999; y0 = 9999; x1 = -1; y1 = -1;
                for (int i = 0; i < NL; i++) begin
                    if (m_valid[i] && root_of(i) == r) begin
                        if (m_x0[i] < x0) x0 = m_x0[i];
                        if (m_y0[i] < y0) y0 = m_y0[i];
                        if (m_x1[i] > x1) x1 = m_x1[i];
                        if (m_y1[i] > y1) y1 = m_y1[i];
                    end
                end
                keep = 1'b1;
`ifdef BBOX_MERGE_MIN_SIZE_EN
                if ((x1 - x0 + 1) < MIN_SZ || (y1 - y0 + 1) < MIN_SZ) keep = 1'b0;
`endif
                if (keep)
                    exp_q.push_back({LABEL_WIDTH'(r), WIDTH_BITS'(x0), HEIGHT_BITS'(y0),
                                     WIDTH_BITS'(x1), HEIGHT_BITS'(y1)});
            end
        end
    endtask

    // Presents one record during COLLECT; called at posedge+1.
    task automatic send_rec(input int lbl, input int par, input int x0, input int y0,
                            input int x1, input int y1);
        int np;
        bbox_valid  = 1'b1;
        bbox_label  = LABEL_WIDTH'(lbl);
        bbox_parent = LABEL_WIDTH'(par);
        bbox_min_x  = WIDTH_BITS'(x0);
        bbox_min_y  = HEIGHT_BITS'(y0);
        bbox_max_x  = WIDTH_BITS'(x1);
        bbox_max_y  = HEIGHT_BITS'(y1);
        @(posedge clk);
        #1 bbox_valid = 1'b0;
        if (lbl >= NL || x0 > x1 || y0 > y1) begin
            exp_drop = 1'b1;
        end else begin
            np = (par >= NL || par > lbl) ? lbl : par;
            if (!m_valid[lbl]) begin
                m_valid[lbl] = 1'b1;
                m_parent[lbl] = np;
                m_x0[lbl] = x0; m_y0[lbl] = y0; m_x1[lbl] = x1; m_y1[lbl] = y1;
            end else begin
                if (np < m_parent[lbl]) m_parent[lbl] = np;
                if (x0 < m_x0[lbl]) m_x0[lbl] = x0;
                if (y0 < m_y0[lbl]) m_y0[lbl] = y0;
                if (x1 > m_x1[lbl]) m_x1[lbl] = x1;
                if (y1 > m_y1[lbl]) m_y1[lbl] = y1;
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        enable = 1'b0; bbox_valid = 1'b0; frame_done = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop_err", drop_err, 1'b0);
        check("rst_data", {out_label, out_min_x, out_min_y, out_max_x, out_max_y}, '0);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        exp_drop = 1'b0;
    endtask

    // Ends the frame and drains the output stream against the model.
    task automatic run_frame(input int stall_first, input bit rnd, input bit inject,
                             input int exp_busy);
        int  n_exp, cyc, empty_pulses, busy_cnt, stall_cnt;
        bit  done, injected;
        build_expected();
        n_exp = exp_q.size();
        frame_done = 1'b1;
        @(posedge clk);
        #1 frame_done = 1'b0;
        model_clear();
        done = 1'b0; cyc = 0; empty_pulses = 0; busy_cnt = 0; stall_cnt = 0; injected = 1'b0;
        while (!done && cyc < 3000) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            enable    = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
            if (out_valid && stall_cnt < stall_first) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            if (inject && out_valid && !injected) begin
                bbox_valid = 1'b1; bbox_label = 8'd3; bbox_parent = 8'd3;
                bbox_min_x = 11'd0; bbox_min_y = 10'd0; bbox_max_x = 11'd100; bbox_max_y = 10'd100;
                injected = 1'b1;
                exp_drop = 1'b1;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            else done = 1'b1;
            if (out_valid) begin
                if (exp_q.size() == 0) check("extra_box", out_valid, 1'b0);
                else check("box", {out_label, out_min_x, out_min_y, out_max_x, out_max_y}, exp_q[0]);
            end
            if (enable && out_last && !out_valid) empty_pulses++;
            if (enable && out_valid && out_ready && exp_q.size() > 0) begin
                check("last_flag", out_last, exp_q.size() == 1);
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1 bbox_valid = 1'b0;
            cyc++;
        end
        enable = 1'b1;
        out_ready = 1'b0;
        check("frame_in_time", done, 1'b1);
        check("boxes_left", exp_q.size(), 0);
        check("empty_pulse", empty_pulses, (n_exp == 0) ? 1 : 0);
        if (exp_busy > 0) check("busy_cycles", busy_cnt, exp_busy);
        check("drop_err", drop_err, exp_drop);
    endtask

    initial begin
        int n, lbl, x0, y0, x1, y1, cyc;
        reset_dut();

        // Two disjoint roots; full turnaround 31 + 32 + 1 cycles.
        send_rec(1, 1, 0, 0, 3, 3);
        send_rec(2, 2, 10, 10, 20, 20);
        run_frame(0, 1'b0, 1'b0, 64);

        // Chain 3 -> 2 -> 1 collapses into label 1.
        send_rec(3, 2, 10, 5, 20, 8);
        send_rec(2, 1, 30, 0, 40, 2);
        send_rec(1, 1, 0, 0, 5, 5);
        run_frame(0, 1'b0, 1'b0, 0);

        // Same label twice, then backpressure on the first box.
        send_rec(5, 5, 5, 5, 9, 9);
        send_rec(5, 5, 2, 7, 6, 12);
        send_rec(9, 9, 100, 100, 120, 130);
        run_frame(10, 1'b0, 1'b0, 0);

        // Out-of-range label, inverted box and a record during EMIT are all dropped.
        send_rec(40, 0, 0, 0, 5, 5);
        send_rec(11, 11, 50, 0, 40, 5);
        send_rec(6, 6, 1, 1, 8, 8);
        run_frame(0, 1'b0, 1'b1, 0);

        // Empty frame.
        reset_dut();
        run_frame(0, 1'b0, 1'b0, 0);

        // Thin box and a 4x4 box.
        send_rec(7, 7, 0, 0, 2, 10);
        send_rec(8, 8, 0, 0, 3, 3);
        run_frame(0, 1'b0, 1'b0, 0);

        // Asynchronous reset while a box is being offered.
        send_rec(4, 4, 1, 1, 9, 9);
        frame_done = 1'b1;
        @(posedge clk);
        #1 frame_done = 1'b0;
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("mid_emit_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        exp_drop = 1'b0;
        run_frame(0, 1'b0, 1'b0, 0);

        // Random frames with random backpressure and enable gaps.
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(0, 20);
            for (int r = 0; r < n; r++) begin
                lbl = $urandom_range(0, 35);
                x0 = $urandom_range(0, 2000);
                y0 = $urandom_range(0, 1000);
                x1 = x0 + $urandom_range(0, 40);
                y1 = y0 + $urandom_range(0, 20);
                if (x1 > 2047) x1 = 2047;
                if (y1 > 1023) y1 = 1023;
                if ($urandom_range(0, 15) == 0) begin
                    int t = x0; x0 = x1 + 1; x1 = t;
                    if (x0 > 2047) x0 = 2047;
                    if (x0 <= x1) x1 = x0 - 1;
                end
                send_rec(lbl, $urandom_range(0, lbl + 4), x0, y0, x1, y1);
            end
            run_frame(0, 1'b1, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
